// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: EX-stage forwarding selects, load-use stall and sticky hazard flag.
// Define FWD_SCOREBOARD_PERF_EN to add saturating stall/forward performance counters.
module fwd_scoreboard #(
   parameter int REG_W   = 5,
   parameter int NUM_SRC = 2,
   parameter int DEPTH   = 2,
   parameter int SEL_W   = 3
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     advance,
   input  logic                     ex_valid,
   input  logic                     ex_flush,
   input  logic                     ex_reg_write,
   input  logic                     ex_mem_read,
   input  logic [REG_W-1:0]         ex_rd,
   input  logic [NUM_SRC*REG_W-1:0] ex_src,
   input  logic                     id_valid,
   input  logic [NUM_SRC*REG_W-1:0] id_src,
   input  logic [NUM_SRC-1:0]       id_src_used,
   output logic [NUM_SRC*SEL_W-1:0] fwd_sel,
   output logic                     load_use_stall,
   output logic                     hazard_err
`ifdef FWD_SCOREBOARD_PERF_EN
   ,
   output logic [31:0]              perf_stall_cnt,
   output logic [31:0]              perf_fwd_cnt
`endif
);
   logic [DEPTH-1:0] e_v;
   logic [REG_W-1:0] e_rd [DEPTH];
   logic             e_ld0;
   logic             new_v, ld_live, haz;
   assign new_v   = ex_valid & ex_reg_write & ~ex_flush & (ex_rd != '0);
   assign ld_live = id_valid & new_v & ex_mem_read;
   // Scan oldest to youngest so the youngest producer overwrites the select.
   always_comb begin
      fwd_sel = '0;
      haz = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         for (int k = DEPTH-1; k >= 0; k--)
            if (e_v[k] && e_rd[k] == ex_src[i*REG_W +: REG_W] && ex_src[i*REG_W +: REG_W] != '0)
               fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k+1);
         haz = haz | (e_v[0] & e_ld0 & (e_rd[0] == ex_src[i*REG_W +: REG_W]) & (ex_src[i*REG_W +: REG_W] != '0));
      end
   end
   always_comb begin
      load_use_stall = 1'b0;
      for (int i = 0; i < NUM_SRC; i++)
         load_use_stall = load_use_stall | (ld_live & id_src_used[i] & (id_src[i*REG_W +: REG_W] == ex_rd));
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         e_v        <= '0;
         e_ld0      <= 1'b0;
         hazard_err <= 1'b0;
         for (int k = 0; k < DEPTH; k++) e_rd[k] <= '0;
      end else if (advance) begin
         e_v        <= {e_v[DEPTH-2:0], new_v};
         e_ld0      <= ex_mem_read;
         hazard_err <= hazard_err | (ex_valid & haz);
         e_rd[0]    <= ex_rd;
         for (int k = 1; k < DEPTH; k++) e_rd[k] <= e_rd[k-1];
      end
`ifdef FWD_SCOREBOARD_PERF_EN
   logic [31:0] n_fwd;
   logic [32:0] fwd_sum;
   always_comb begin
      n_fwd = '0;
      for (int i = 0; i < NUM_SRC; i++)
         n_fwd = n_fwd + ((fwd_sel[i*SEL_W +: SEL_W] != '0) ? 32'd1 : 32'd0);
   end
   assign fwd_sum = {1'b0, perf_fwd_cnt} + {1'b0, n_fwd};
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         perf_stall_cnt <= '0;
         perf_fwd_cnt   <= '0;
      end else if (advance) begin
         perf_stall_cnt <= (load_use_stall && perf_stall_cnt != '1) ? perf_stall_cnt + 32'd1 : perf_stall_cnt;
         perf_fwd_cnt   <= !ex_valid ? perf_fwd_cnt : fwd_sum[32] ? '1 : fwd_sum[31:0];
      end
`endif
endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb_fwd_scoreboard: directed scoreboard bench for fwd_scoreboard (DEPTH=3 when FWD_SCOREBOARD_PERF_EN).
module tb_fwd_scoreboard;
`ifdef FWD_SCOREBOARD_PERF_EN
   localparam int D = 3;
`else
   localparam int D = 2;
`endif
   logic        clk = 1'b0, reset, advance;
   logic        ex_valid, ex_flush, ex_reg_write, ex_mem_read, id_valid;
   logic [4:0]  ex_rd;
   logic [9:0]  ex_src, id_src;
   logic [1:0]  id_src_used;
   logic [5:0]  fwd_sel;
   logic        load_use_stall, hazard_err;
`ifdef FWD_SCOREBOARD_PERF_EN
   logic [31:0] psc, pfc;
`endif
   typedef struct {string tag; logic [31:0] v;} exp_t;
   exp_t q[$];
   int n_pass = 0, n_total = 0;

   fwd_scoreboard #(.DEPTH(D)) dut (
      .clk(clk), .reset(reset), .advance(advance), .ex_valid(ex_valid), .ex_flush(ex_flush),
      .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_src(ex_src),
      .id_valid(id_valid), .id_src(id_src), .id_src_used(id_src_used), .fwd_sel(fwd_sel),
      .load_use_stall(load_use_stall), .hazard_err(hazard_err)
`ifdef FWD_SCOREBOARD_PERF_EN
      , .perf_stall_cnt(psc), .perf_fwd_cnt(pfc)
`endif
   );

   always #5 clk = ~clk;

   task automatic exp_push(input string tag, input logic [31:0] v);
      q.push_back('{tag, v});
   endtask
   task automatic chk(input logic [31:0] obs);
      exp_t e;
      n_total++;
      if (q.size() == 0) begin
         $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
      end else begin
         e = q.pop_front();
         assert (obs === e.v) n_pass++;
         else $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.v);
      end
   endtask
   function automatic logic [31:0] sel(input int i);
      return 32'(fwd_sel[i*3 +: 3]);
   endfunction
   task automatic ex(input logic v, wr, ld, fl, input logic [4:0] rd, s0, s1);
      ex_valid = v; ex_reg_write = wr; ex_mem_read = ld; ex_flush = fl;
      ex_rd = rd; ex_src = {s1, s0};
   endtask
   task automatic id(input logic v, input logic [4:0] s0, s1, input logic [1:0] used);
      id_valid = v; id_src = {s1, s0}; id_src_used = used;
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; advance = 1'b1;
      ex(1, 1, 0, 0, 5'd3, 5'd3, 5'd3); id(0, 0, 0, 2'b00);
      #2;
      exp_push("rst_sel0", 0);  chk(sel(0));
      exp_push("rst_stall", 0); chk(32'(load_use_stall));
      exp_push("rst_haz", 0);   chk(32'(hazard_err));
      @(negedge clk); reset = 1'b0;
      // ALU chain: add $3 ; sub $5,$3,$4 ; or $6,$4,$3
      ex(1, 1, 0, 0, 5'd3, 5'd1, 5'd2); #1;
      exp_push("chain_empty", 0); chk(sel(0));
      tick; ex(1, 1, 0, 0, 5'd5, 5'd3, 5'd4); #1;
      exp_push("chain_mem_op0", 1); chk(sel(0));
      exp_push("chain_mem_op1", 0); chk(sel(1));
      tick; ex(1, 1, 0, 0, 5'd6, 5'd4, 5'd3); #1;
      exp_push("chain_wb_op1", 2); chk(sel(1));
      exp_push("chain_wb_op0", 0); chk(sel(0));
      // Double producer of $2
      tick; ex(1, 1, 0, 0, 5'd2, 5'd0, 5'd0);
      tick; ex(1, 1, 0, 0, 5'd2, 5'd0, 5'd0);
      tick; ex(1, 0, 0, 0, 5'd9, 5'd2, 5'd2); #1;
      exp_push("dbl_op0", 1); chk(sel(0));
      exp_push("dbl_op1", 1); chk(sel(1));
      tick; ex(0, 0, 0, 0, 5'd0, 5'd2, 5'd2); #1;
      exp_push("dbl_older_op0", 2); chk(sel(0));
      // Load-use: lw $8 in EX, consumer in ID
      tick; ex(1, 1, 1, 0, 5'd8, 5'd1, 5'd0); id(1, 5'd8, 5'd4, 2'b01); #1;
      exp_push("lu_stall", 1); chk(32'(load_use_stall));
      id(1, 5'd8, 5'd4, 2'b10); #1;
      exp_push("lu_unused_src", 0); chk(32'(load_use_stall));
      id(1, 5'd8, 5'd4, 2'b01);
      tick; ex(0, 0, 0, 0, 5'd0, 5'd0, 5'd0); #1;
      exp_push("lu_bubble_stall", 0); chk(32'(load_use_stall));
      tick; ex(1, 1, 0, 0, 5'd10, 5'd8, 5'd4); id(0, 0, 0, 2'b00); #1;
      exp_push("lu_fwd_wb", 2); chk(sel(0));
      tick; ex(0, 0, 0, 0, 5'd0, 5'd0, 5'd0); #1;
      exp_push("lu_no_haz", 0); chk(32'(hazard_err));
      // Unbubbled load consumer sets the sticky hazard flag
      ex(1, 1, 1, 0, 5'd9, 5'd0, 5'd0);
      tick; ex(1, 1, 0, 0, 5'd11, 5'd9, 5'd0); #1;
      exp_push("haz_sel", 1); chk(sel(0));
      tick; ex(0, 0, 0, 0, 5'd0, 5'd0, 5'd0); #1;
      exp_push("haz_set", 1); chk(32'(hazard_err));
      // Register 0
      ex(1, 1, 1, 0, 5'd0, 5'd0, 5'd0); id(1, 5'd0, 5'd0, 2'b11); #1;
      exp_push("r0_stall", 0); chk(32'(load_use_stall));
      tick; ex(1, 0, 0, 0, 5'd1, 5'd0, 5'd0); id(0, 0, 0, 2'b00); #1;
      exp_push("r0_sel0", 0); chk(sel(0));
      exp_push("r0_sel1", 0); chk(sel(1));
      // Flushed load writing $7
      tick; ex(1, 1, 1, 1, 5'd7, 5'd0, 5'd0); id(1, 5'd7, 5'd0, 2'b01); #1;
      exp_push("flush_stall", 0); chk(32'(load_use_stall));
      tick; ex(1, 0, 0, 0, 5'd1, 5'd7, 5'd7); id(0, 0, 0, 2'b00); #1;
      exp_push("flush_sel0", 0); chk(sel(0));
      exp_push("flush_sel1", 0); chk(sel(1));
      // Freeze for 3 cycles, then reset mid-freeze
      tick; ex(1, 1, 0, 0, 5'd10, 5'd0, 5'd0);
      tick; advance = 1'b0; ex(1, 1, 0, 0, 5'd11, 5'd10, 5'd11);
      for (int c = 0; c < 3; c++) begin
         #1;
         exp_push("frz_sel0", 1); chk(sel(0));
         exp_push("frz_sel1", 0); chk(sel(1));
         tick;
      end
      exp_push("frz_haz", 1); chk(32'(hazard_err));
      reset = 1'b1; #1;
      exp_push("rst_frz_sel0", 0); chk(sel(0));
      exp_push("rst_frz_haz", 0); chk(32'(hazard_err));
      ex(1, 1, 1, 0, 5'd12, 5'd0, 5'd0); id(1, 5'd0, 5'd12, 2'b10); #1;
      exp_push("rst_live_stall", 1); chk(32'(load_use_stall));
      ex(0, 0, 0, 0, 5'd0, 5'd0, 5'd0); id(0, 0, 0, 2'b00); advance = 1'b1;
      tick; reset = 1'b0;
`ifdef FWD_SCOREBOARD_PERF_EN
      #1;
      exp_push("perf_rst_stall", 0); chk(psc);
      exp_push("perf_rst_fwd", 0);   chk(pfc);
      tick; ex(1, 1, 0, 0, 5'd13, 5'd0, 5'd0);
      tick; ex(1, 0, 0, 0, 5'd1, 5'd13, 5'd13);
      tick; ex(1, 0, 0, 0, 5'd1, 5'd0, 5'd0);
      tick; ex(1, 0, 0, 0, 5'd1, 5'd13, 5'd0); #1;
      exp_push("d3_postwb_sel", 3); chk(sel(0));
      tick; ex(1, 1, 1, 0, 5'd14, 5'd0, 5'd0); id(1, 5'd14, 5'd0, 2'b01);
      tick; ex(0, 0, 0, 0, 5'd0, 5'd0, 5'd0); id(0, 0, 0, 2'b00); #1;
      exp_push("perf_stall_cnt", 1); chk(psc);
      exp_push("perf_fwd_cnt", 3);   chk(pfc);
      advance = 1'b0; ex(1, 1, 1, 0, 5'd15, 5'd0, 5'd0); id(1, 5'd15, 5'd0, 2'b01);
      tick; #1;
      exp_push("perf_frz_stall", 1); chk(psc);
      ex(0, 0, 0, 0, 5'd0, 5'd0, 5'd0); id(0, 0, 0, 2'b00); advance = 1'b1;
`endif
      tick;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
